// File: rtl/ft_alu_pipe_if.sv
// rtl/ft_alu_pipe_if.sv - operand/result handshake and error status bundle for ft_alu_pipe
interface ft_alu_pipe_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             par;
  logic [2:0]       ctl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             xc;
  logic             yc;
  logic [1:0]       xe;
  logic [1:0]       ye;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic             clr;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, par, ctl, out_ready, clr,
    input  in_ready, out_valid, x, y, xc, yc, xe, ye, err_sticky, err_cnt
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, par, ctl, out_ready, clr,
    output in_ready, out_valid, x, y, xc, yc, xe, ye, err_sticky, err_cnt
  );
endinterface

// File: rtl/ft_alu_pipe.sv
// rtl/ft_alu_pipe.sv - fault-tolerant two-stage duplicated adder/subtractor; optional error counter via FT_ALU_PIPE_ERRCNT_EN
module ft_alu_pipe #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ft_alu_pipe_if.slave bus
);

  localparam logic [1:0] CODE_OK  = 2'b10;
  localparam logic [1:0] CODE_ERR = 2'b11;

  // Bit-serial ripple formulation so the shadow adder is structurally distinct from the primary '+'
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
    logic             c;
    logic [WIDTH-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = p[i] ^ q[i] ^ c;
      c    = (p[i] & q[i]) | (c & (p[i] ^ q[i]));
    end
    return {c, s};
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_ctl_q;
  logic             s1_cw_ok_q, s1_ctl_ok_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] x_q, y_q;
  logic             xc_q, yc_q;
  logic [1:0]       xe_q, ye_q;

  logic             err_sticky_q, err_sticky_d;

  logic s2_ready, s1_adv, accept, out_hs, out_err;

  // Stage-2 combinational datapath
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   x_prim, x_shad, y_prim, y_shad;
  logic [1:0]       xe_d, ye_d;
  logic             chk_ok;

  assign s2_ready = !s2_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_hs   = s2_valid_q && bus.out_ready;
  assign out_err  = (xe_q != CODE_OK) || (ye_q != CODE_OK);

  assign bus.in_ready   = !s1_valid_q || s2_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.xc         = xc_q;
  assign bus.yc         = yc_q;
  assign bus.xe         = xe_q;
  assign bus.ye         = ye_q;
  assign bus.err_sticky = err_sticky_q;

  // Operand negation, duplicated adders per channel and error-code formation
  always_comb begin
    op_a   = s1_ctl_q[2] ? (~s1_a_q + WIDTH'(1)) : s1_a_q;
    op_b   = s1_ctl_q[1] ? (~s1_b_q + WIDTH'(1)) : s1_b_q;
    x_prim = {1'b0, op_a} + {1'b0, op_b};
    x_shad = ripple_add(op_a, op_b);
    y_prim = {1'b0, op_a} + {1'b0, op_b};
    y_shad = ripple_add(op_a, op_b);
    chk_ok = s1_cw_ok_q && s1_ctl_ok_q;
    xe_d   = (chk_ok && (x_prim == x_shad)) ? CODE_OK : CODE_ERR;
    ye_d   = (chk_ok && (y_prim == y_shad)) ? CODE_OK : CODE_ERR;
  end

  // Valid-bit and sticky next-state; clear wins over a coincident error event
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s2_valid_d   = s2_valid_q;
    err_sticky_d = err_sticky_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    if (bus.clr) begin
      err_sticky_d = 1'b0;
    end else if (out_hs && out_err) begin
      err_sticky_d = 1'b1;
    end
  end

  // Stage 1: capture operands with their codeword and control checks on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctl_q    <= '0;
      s1_cw_ok_q  <= 1'b0;
      s1_ctl_ok_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_a_q      <= bus.a;
        s1_b_q      <= bus.b;
        s1_ctl_q    <= bus.ctl;
        s1_cw_ok_q  <= ^{bus.a, bus.b, bus.par};
        s1_ctl_ok_q <= $onehot(bus.ctl);
      end
    end
  end

  // Stage 2: results only load when stage 1 advances, so they hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xc_q       <= 1'b0;
      yc_q       <= 1'b0;
      xe_q       <= CODE_ERR;
      ye_q       <= CODE_ERR;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        x_q  <= x_prim[WIDTH-1:0];
        xc_q <= x_prim[WIDTH];
        y_q  <= y_prim[WIDTH-1:0];
        yc_q <= y_prim[WIDTH];
        xe_q <= xe_d;
        ye_q <= ye_d;
      end
    end
  end

  // Sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef FT_ALU_PIPE_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of errored result handshakes
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clr) begin
      err_cnt_d = '0;
    end else if (out_hs && out_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = {CNT_W{1'b0}};
`endif

endmodule
